parity_frame_tx: RTL and testbench

Serial frame transmitter that sequences a serial parity accumulator. Accepts a parallel data word over a valid/ready handshake and emits one frame on a single line: start bit, data bits LSB-first, parity bit, stop bit. Parity is built bit-serially while the data is shifted out. The block sits between a parallel producer and a serial link, and owns bit timing and frame sequencing.

---
 rtl/parity_frame_pkg.sv | 31 +++
 rtl/parity_frame_tx_parity_accum.sv | 45 ++++
 rtl/parity_frame_tx.sv | 135 +++++++++++++
 tb/tb_parity_frame_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_frame_pkg.sv
// Shared types and constants for the parity frame transmitter.
package parity_frame_pkg;

    // Start, stop and parity bits added around every data word.
    localparam int FRAME_OVERHEAD_BITS = 3;

    // Frame bit count for the default 8-bit word.
    localparam int DEFAULT_DATA_W     = 8;
    localparam int DEFAULT_FRAME_BITS = DEFAULT_DATA_W + FRAME_OVERHEAD_BITS;

    // Frame sequencing states of the transmitter controller.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } frame_state_t;

    // States of the serial parity accumulator.
    typedef enum logic {
        ACC_EVEN = 1'b0,
        ACC_ODD  = 1'b1
    } acc_state_t;

    // Total serial bits per frame for a given data width (DATA_W + 3).
    function automatic int frame_bits(input int data_w);
        return data_w + FRAME_OVERHEAD_BITS;
    endfunction

endpackage

// File: rtl/parity_frame_tx_parity_accum.sv
// Two-state serial parity accumulator: tracks whether an even or odd
// number of ones has been absorbed since the last clear.
module parity_accum
    import parity_frame_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic bit_valid,
    input  logic bit_in,
    output logic parity
);

    acc_state_t r_state;
    acc_state_t w_state_next;

    // State register, cleared asynchronously to EVEN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ACC_EVEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: clear wins; otherwise a valid one toggles the parity.
    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = ACC_EVEN;
        end else if (bit_valid && bit_in) begin
            case (r_state)
                ACC_EVEN: w_state_next = ACC_ODD;
                ACC_ODD:  w_state_next = ACC_EVEN;
                default:  w_state_next = ACC_EVEN;
            endcase
        end
    end

    // Output: XOR of all absorbed bits.
    always_comb begin
        parity = (r_state == ACC_ODD);
    end

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB-first,
// parity bit, stop bit. Parity is built bit-serially while shifting.
module parity_frame_tx
    import parity_frame_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 1,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(BIT_CYCLES + 1);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic             ODD_BIT  = (ODD_PARITY != 0);

    frame_state_t      r_state;
    frame_state_t      w_state_next;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [IDX_W-1:0]  r_bit_idx;
    logic              r_frame_done;

    logic w_accept;
    logic w_bit_end;
    logic w_last_data;
    logic w_absorb;
    logic w_parity;

    assign w_accept    = (r_state == ST_IDLE) && in_valid;
    assign w_bit_end   = (r_bit_cnt == CNT_LAST);
    assign w_last_data = (r_bit_idx == IDX_LAST);
    assign w_absorb    = (r_state == ST_DATA) && w_bit_end;

    // The accumulator only sees a bit at the end of each data-bit slot.
    parity_accum u_parity_accum (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_accept),
        .bit_valid (w_absorb),
        .bit_in    (r_shift[0]),
        .parity    (w_parity)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; each non-idle state advances at its bit boundary.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (in_valid)                  w_state_next = ST_START;
            ST_START:  if (w_bit_end)                 w_state_next = ST_DATA;
            ST_DATA:   if (w_bit_end && w_last_data)  w_state_next = ST_PARITY;
            ST_PARITY: if (w_bit_end)                 w_state_next = ST_STOP;
            ST_STOP:   if (w_bit_end)                 w_state_next = ST_IDLE;
            default:                                  w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: capture on accept, bit timing, shifting and data index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
        end else if (w_accept) begin
            r_shift   <= in_data;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
        end else if (r_state != ST_IDLE) begin
            if (w_bit_end) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (w_absorb) begin
                r_shift <= r_shift >> 1;
                // Index saturates at the last bit; the PARITY move takes over.
                if (!w_last_data) begin
                    r_bit_idx <= r_bit_idx + IDX_W'(1);
                end
            end
        end
    end

    // Completion pulse lands in the first IDLE cycle after the stop bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= (r_state == ST_STOP) && w_bit_end;
        end
    end

    // Output decode from the current state.
    always_comb begin
        tx       = 1'b1;
        in_ready = 1'b0;
        busy     = 1'b1;
        case (r_state)
            ST_IDLE: begin
                tx       = 1'b1;
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = r_shift[0];
            ST_PARITY: tx = w_parity ^ ODD_BIT;
            ST_STOP:   tx = 1'b1;
            default: begin
                tx       = 1'b1;
                in_ready = 1'b0;
                busy     = 1'b1;
            end
        endcase
        frame_done = r_frame_done;
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed testbench for parity_frame_tx: three instances cover even
// parity, odd parity and a four-cycle bit period.
module tb_parity_frame_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
    logic       ready_a, ready_b, ready_c;
    logic       tx_a, tx_b, tx_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    parity_frame_tx #(.DATA_W(8), .BIT_CYCLES(1), .ODD_PARITY(0)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(valid_a),
        .in_ready(ready_a), .tx(tx_a), .busy(busy_a), .frame_done(done_a)
    );

    parity_frame_tx #(.DATA_W(8), .BIT_CYCLES(1), .ODD_PARITY(1)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(valid_b),
        .in_ready(ready_b), .tx(tx_b), .busy(busy_b), .frame_done(done_b)
    );

    parity_frame_tx #(.DATA_W(8), .BIT_CYCLES(4), .ODD_PARITY(0)) dut_c (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(valid_c),
        .in_ready(ready_c), .tx(tx_c), .busy(busy_c), .frame_done(done_c)
    );

    // Reset state of all instances, asserted before any clock edge.
    task automatic test_reset();
        #1;
        checks++;
        if ({tx_a, tx_b, tx_c} !== 3'b111) begin
            errors++; $display("FAIL reset_tx: got %b want 111", {tx_a, tx_b, tx_c});
        end
        checks++;
        if ({ready_a, ready_b, ready_c} !== 3'b111) begin
            errors++; $display("FAIL reset_ready: got %b want 111", {ready_a, ready_b, ready_c});
        end
        checks++;
        if ({busy_a, busy_b, busy_c} !== 3'b000) begin
            errors++; $display("FAIL reset_busy: got %b want 000", {busy_a, busy_b, busy_c});
        end
        checks++;
        if ({done_a, done_b, done_c} !== 3'b000) begin
            errors++; $display("FAIL reset_done: got %b want 000", {done_a, done_b, done_c});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_a, busy_b, busy_c} !== 3'b000) begin
            errors++; $display("FAIL idle_busy: got %b want 000", {busy_a, busy_b, busy_c});
        end
        $display("reset: outputs checked");
    endtask

    // 8'hA5, even parity, one cycle per bit.
    task automatic test_frame_even();
        int seq[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
        in_data = 8'hA5;
        valid_a = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            valid_a = 1'b0;
            checks++;
            if (tx_a !== 1'(seq[i])) begin
                errors++; $display("FAIL a5_bit%0d: tx=%b want %0d", i, tx_a, seq[i]);
            end
            checks++;
            if (busy_a !== 1'b1 || ready_a !== 1'b0) begin
                errors++; $display("FAIL a5_busy%0d: busy=%b ready=%b want 1/0", i, busy_a, ready_a);
            end
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || ready_a !== 1'b1 || tx_a !== 1'b1) begin
            errors++; $display("FAIL a5_done: done=%b ready=%b tx=%b want 1/1/1", done_a, ready_a, tx_a);
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0) begin
            errors++; $display("FAIL a5_done_pulse: done=%b want 0", done_a);
        end
        $display("frame A5 even: sent");
    endtask

    // 8'h07 on even (parity 1) and odd (parity 0) instances at once.
    task automatic test_odd_parity();
        int seq[11] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
        int exp_b;
        in_data = 8'h07;
        valid_a = 1'b1;
        valid_b = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            valid_a = 1'b0;
            valid_b = 1'b0;
            exp_b = (i == 9) ? 0 : seq[i];
            checks++;
            if (tx_a !== 1'(seq[i])) begin
                errors++; $display("FAIL even07_bit%0d: tx=%b want %0d", i, tx_a, seq[i]);
            end
            checks++;
            if (tx_b !== 1'(exp_b)) begin
                errors++; $display("FAIL odd07_bit%0d: tx=%b want %0d", i, tx_b, exp_b);
            end
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || done_b !== 1'b1) begin
            errors++; $display("FAIL p07_done: done_a=%b done_b=%b want 1/1", done_a, done_b);
        end
        @(negedge clk);
        $display("frame 07 even/odd: sent");
    endtask

    // 8'h80 with four cycles per bit: 44 frame cycles.
    task automatic test_slow_bits();
        logic exp;
        in_data = 8'h80;
        valid_c = 1'b1;
        for (int c = 0; c < 44; c++) begin
            @(negedge clk);
            valid_c = 1'b0;
            exp = (c >= 32);
            checks++;
            if (tx_c !== exp) begin
                errors++; $display("FAIL slow_cyc%0d: tx=%b want %b", c, tx_c, exp);
            end
            checks++;
            if (busy_c !== 1'b1 || done_c !== 1'b0) begin
                errors++; $display("FAIL slow_busy%0d: busy=%b done=%b want 1/0", c, busy_c, done_c);
            end
        end
        @(negedge clk);
        checks++;
        if (done_c !== 1'b1 || busy_c !== 1'b0 || ready_c !== 1'b1) begin
            errors++; $display("FAIL slow_done: done=%b busy=%b ready=%b want 1/0/1", done_c, busy_c, ready_c);
        end
        @(negedge clk);
        $display("frame 80 slow: sent");
    endtask

    // in_valid held across two words; in_data changes mid-frame.
    task automatic test_back_to_back();
        // Cycles 1..23: frame 01, one idle slot, frame FE.
        int seq[23] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1,
                        1,
                        0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        logic exp_ready;
        in_data = 8'h01;
        valid_a = 1'b1;
        for (int k = 0; k < 23; k++) begin
            @(negedge clk);
            if (k == 0)  in_data = 8'hFE;
            if (k == 12) begin
                valid_a = 1'b0;
                in_data = 8'h00;
            end
            exp_ready = (k == 11);
            checks++;
            if (tx_a !== 1'(seq[k])) begin
                errors++; $display("FAIL b2b_cyc%0d: tx=%b want %0d", k + 1, tx_a, seq[k]);
            end
            checks++;
            if (ready_a !== exp_ready) begin
                errors++; $display("FAIL b2b_ready%0d: ready=%b want %b", k + 1, ready_a, exp_ready);
            end
            if (k == 11) begin
                checks++;
                if (done_a !== 1'b1) begin
                    errors++; $display("FAIL b2b_done1: done=%b want 1", done_a);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || ready_a !== 1'b1) begin
            errors++; $display("FAIL b2b_done2: done=%b ready=%b want 1/1", done_a, ready_a);
        end
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: busy=%b done=%b want 0/0", busy_a, done_a);
        end
        $display("back-to-back 01/FE: sent");
    endtask

    // Reset during data bit 3 of 8'hFF, then an 8'h00 frame.
    task automatic test_reset_mid_frame();
        int seq[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        in_data = 8'hFF;
        valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid_a = 1'b0;
        end
        checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b1) begin
            errors++; $display("FAIL mid_bit3: tx=%b busy=%b want 1/1", tx_a, busy_a);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || ready_a !== 1'b1 || done_a !== 1'b0) begin
            errors++; $display("FAIL mid_reset: tx=%b busy=%b ready=%b done=%b want 1/0/1/0",
                               tx_a, busy_a, ready_a, done_a);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (done_a !== 1'b0 || busy_a !== 1'b0 || tx_a !== 1'b1) begin
                errors++; $display("FAIL mid_nodone%0d: done=%b busy=%b tx=%b want 0/0/1", i, done_a, busy_a, tx_a);
            end
        end
        in_data = 8'h00;
        valid_a = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            valid_a = 1'b0;
            checks++;
            if (tx_a !== 1'(seq[i])) begin
                errors++; $display("FAIL after_reset_bit%0d: tx=%b want %0d", i, tx_a, seq[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1) begin
            errors++; $display("FAIL after_reset_done: done=%b want 1", done_a);
        end
        $display("reset mid-frame then 00: sent");
    endtask

    initial begin
        test_reset();
        test_frame_even();
        test_odd_parity();
        test_slow_bits();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
